qpsk_rx_sequencer: RTL

Control and framing block behind the QPSK demodulator chain. It replaces the free-running symbol clock with a symbol strobe derived from the sample clock and holds off decisions until the I/Q filters have settled. It then hunts the demodulated dibit stream for a sync word and packs the following payload dibits into bytes, delivered over a valid/ready handshake. It sits between the demodulator's I/Q decision outputs and the byte-level receive logic.

---
 rtl/qpsk_rx_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/qpsk_rx_sequencer.sv
// Purpose: symbol strobe, filter warm-up, sync-word hunt and dibit-to-byte packing after the QPSK demodulator.
// Latency: byte_valid/byte_data/frame_done/locked update on the edge that samples the relevant dibit (1 cycle).
// Backpressure: single byte register; a byte completing while the previous one is unconsumed is dropped and overflow latches.
module qpsk_rx_sequencer #(
  parameter int unsigned SPS           = 16,
  parameter int unsigned WARMUP        = 64,
  parameter logic [15:0] SYNC_WORD     = 16'hA5F0,
  parameter int unsigned PAYLOAD_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       i_bit,
  input  logic       q_bit,
  output logic       sym_tick,
  output logic       locked,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_done,
  output logic       overflow
);

  localparam int unsigned SYM_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned WU_W  = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_HUNT    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SYM_W-1:0] r_sym_cnt;
  logic             r_sym_tick;
  logic [WU_W-1:0]  r_warm_cnt;
  logic [15:0]      r_sreg;
  logic [3:0]       r_hunt_cnt;
  logic [5:0]       r_byte_sh;
  logic [1:0]       r_dibit_cnt;
  logic [7:0]       r_byte_cnt;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_frame_done;
  logic             r_overflow;

  logic [15:0]      w_sreg_nxt;
  logic [3:0]       w_hunt_cnt_nxt;
  logic [7:0]       w_byte_nxt;
  logic             w_hunt_shift;
  logic             w_match;
  logic             w_pay_shift;
  logic             w_byte_done;
  logic             w_frame_end;

  assign sym_tick   = r_sym_tick;
  assign locked     = (r_state == S_PAYLOAD);
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode plus the per-tick shift/complete strobes that drive the datapath.
  always_comb begin
    w_state_nxt    = r_state;
    w_hunt_shift   = 1'b0;
    w_match        = 1'b0;
    w_pay_shift    = 1'b0;
    w_byte_done    = 1'b0;
    w_frame_end    = 1'b0;
    w_sreg_nxt     = {r_sreg[13:0], i_bit, q_bit};
    w_hunt_cnt_nxt = (r_hunt_cnt == 4'd8) ? 4'd8 : r_hunt_cnt + 4'd1;
    w_byte_nxt     = {r_byte_sh, i_bit, q_bit};
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_WARMUP;
        S_WARMUP: begin
          if (r_warm_cnt == WU_W'(WARMUP - 1)) w_state_nxt = S_HUNT;
        end
        S_HUNT: begin
          if (r_sym_tick) begin
            w_hunt_shift = 1'b1;
            if ((w_hunt_cnt_nxt == 4'd8) && (w_sreg_nxt == SYNC_WORD)) begin
              w_match     = 1'b1;
              w_state_nxt = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (r_sym_tick) begin
            w_pay_shift = 1'b1;
            if (r_dibit_cnt == 2'd3) begin
              w_byte_done = 1'b1;
              if (r_byte_cnt == 8'(PAYLOAD_BYTES - 1)) begin
                w_frame_end = 1'b1;
                w_state_nxt = S_HUNT;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Symbol counter and registered strobe; phase restarts only on leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_cnt  <= '0;
      r_sym_tick <= 1'b0;
    end else if (!enable || (r_state == S_IDLE)) begin
      r_sym_cnt  <= '0;
      r_sym_tick <= 1'b0;
    end else begin
      r_sym_tick <= (r_sym_cnt == SYM_W'(SPS - 1));
      r_sym_cnt  <= (r_sym_cnt == SYM_W'(SPS - 1)) ? '0 : r_sym_cnt + SYM_W'(1);
    end
  end

  // Filter settling counter, active only while in WARMUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_warm_cnt <= '0;
    else if (!enable || (r_state == S_IDLE))   r_warm_cnt <= '0;
    else if (r_state == S_WARMUP)              r_warm_cnt <= r_warm_cnt + WU_W'(1);
  end

  // Sync hunt shift register and saturating dibit count; cleared after each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg     <= '0;
      r_hunt_cnt <= '0;
    end else if (!enable || w_frame_end) begin
      r_sreg     <= '0;
      r_hunt_cnt <= '0;
    end else if (w_hunt_shift) begin
      r_sreg     <= w_sreg_nxt;
      r_hunt_cnt <= w_hunt_cnt_nxt;
    end
  end

  // Payload byte assembler and frame byte counter; frame_done pulses after the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_sh    <= '0;
      r_dibit_cnt  <= '0;
      r_byte_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (!enable || w_match) begin
        r_byte_sh   <= '0;
        r_dibit_cnt <= '0;
        r_byte_cnt  <= '0;
      end else if (w_pay_shift) begin
        r_byte_sh   <= w_byte_nxt[5:0];
        r_dibit_cnt <= r_dibit_cnt + 2'd1;
        if (w_byte_done) r_byte_cnt <= r_byte_cnt + 8'd1;
      end
    end
  end

  // Output byte register: load when empty or being drained, otherwise drop and flag overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_byte_done && (!r_byte_valid || byte_ready)) begin
      r_byte_data  <= w_byte_nxt;
      r_byte_valid <= 1'b1;
    end else begin
      if (w_byte_done)                 r_overflow   <= 1'b1;
      if (r_byte_valid && byte_ready)  r_byte_valid <= 1'b0;
    end
  end

endmodule
